// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_MULU = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_MULS = 2'b10;
   localparam logic [1:0] OP_DIVS = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step, or restoring divide step.
// acc holds the high partial product / partial remainder; wrk holds multiplier / quotient bits.
module muldiv_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] wrk_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] wrk_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      sum     = {1'b0, acc_i} + (wrk_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {acc_i, wrk_i[WIDTH-1]};
      trial   = shifted - {1'b0, opnd_i};
      if (is_div) begin
         // A borrow out of the trial subtract means the divisor did not fit: restore.
         if (trial[WIDTH]) begin
            acc_o = shifted[WIDTH-1:0];
            wrk_o = {wrk_i[WIDTH-2:0], 1'b0};
         end else begin
            acc_o = trial[WIDTH-1:0];
            wrk_o = {wrk_i[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_o = sum[WIDTH:1];
         wrk_o = {sum[0], wrk_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and start/busy/done handshake.
// Define MULDIV_SIGNED_EN to honour op[1] (MULS/DIVS); otherwise every op is unsigned.
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             HIin,
   input  logic             LOin,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] wrk_q, wrk_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic             b_zero_q, b_zero_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_acc, step_wrk;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] res_hi, res_lo;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + (2*WIDTH)'(1);
   endfunction

   muldiv_iter_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div (is_div_q),
      .acc_i  (acc_q),
      .wrk_i  (wrk_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc),
      .wrk_o  (step_wrk)
   );

`ifdef MULDIV_SIGNED_EN
   logic sgn_a_q, sgn_a_d;
   logic sgn_b_q, sgn_b_d;

   assign a_mag = (op[1] && A[WIDTH-1]) ? neg_w(A) : A;
   assign b_mag = (op[1] && B[WIDTH-1]) ? neg_w(B) : B;

   always_comb begin
      sgn_a_d = sgn_a_q;
      sgn_b_d = sgn_b_q;
      if (state_q == IDLE && start) begin
         sgn_a_d = op[1] & A[WIDTH-1];
         sgn_b_d = op[1] & B[WIDTH-1];
      end
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         sgn_a_q <= 1'b0;
         sgn_b_q <= 1'b0;
      end else begin
         sgn_a_q <= sgn_a_d;
         sgn_b_q <= sgn_b_d;
      end
   end

   // Quotient takes the XOR of the signs, remainder the dividend sign.
   always_comb begin
      res_hi = acc_q;
      res_lo = wrk_q;
      if (is_div_q) begin
         if (sgn_a_q ^ sgn_b_q) res_lo = neg_w(wrk_q);
         if (sgn_a_q)           res_hi = neg_w(acc_q);
      end else if (sgn_a_q ^ sgn_b_q) begin
         {res_hi, res_lo} = neg_2w({acc_q, wrk_q});
      end
   end
`else
   logic unused_op_sign;
   assign unused_op_sign = op[1];
   assign a_mag  = A;
   assign b_mag  = B;
   assign res_hi = acc_q;
   assign res_lo = wrk_q;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      wrk_d    = wrk_q;
      opnd_d   = opnd_q;
      a_d      = a_q;
      is_div_d = is_div_q;
      b_zero_d = b_zero_q;
      dbz_d    = dbz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      // Bus loads are only honoured while no result write can collide with them.
      if (state_q == IDLE || state_q == DONE) begin
         if (HIin) hi_d = bus_in;
         if (LOin) lo_d = bus_in;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               cnt_d    = '0;
               acc_d    = '0;
               wrk_d    = a_mag;
               opnd_d   = b_mag;
               a_d      = A;
               is_div_d = op[0];
               b_zero_d = (B == '0);
               dbz_d    = 1'b0;
            end
         end
         RUN: begin
            acc_d = step_acc;
            wrk_d = step_wrk;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            if (is_div_q && b_zero_q) begin
               hi_d  = a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d = res_hi;
               lo_d = res_lo;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         wrk_q    <= '0;
         opnd_q   <= '0;
         a_q      <= '0;
         is_div_q <= 1'b0;
         b_zero_q <= 1'b0;
         dbz_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         wrk_q    <= wrk_d;
         opnd_q   <= opnd_d;
         a_q      <= a_d;
         is_div_q <= is_div_d;
         b_zero_q <= b_zero_d;
         dbz_q    <= dbz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign HI          = hi_q;
   assign LO          = lo_q;
   assign busy        = (state_q == RUN) || (state_q == FIX);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: driver pushes expected results, monitor checks on done.
module tb_muldiv_hilo_unit;

   localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic          Clock, Clear, start, HIin, LOin;
   logic [1:0]    op;
   logic [W-1:0]  A, B, bus_in, HI, LO;
   logic          busy, done, div_by_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc;
   int          n_cmp, n_bad;
   logic [31:0] mdl_hi, mdl_lo;

   muldiv_hilo_unit #(.WIDTH(W)) dut (
      .Clock       (Clock),
      .Clear       (Clear),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .bus_in      (bus_in),
      .HIin        (HIin),
      .LOin        (LOin),
      .HI          (HI),
      .LO          (LO),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output logic edz);
      longint xa, xb;
      logic [63:0] p, q, r;
      bit sg;
      sg  = SIGNED_EN && o[1];
      xa  = sg ? longint'($signed(a)) : longint'({32'd0, a});
      xb  = sg ? longint'($signed(b)) : longint'({32'd0, b});
      edz = 1'b0;
      if (!o[0]) begin
         p  = xa * xb;
         eh = p[63:32];
         el = p[31:0];
      end else if (b == 32'd0) begin
         el  = 32'hFFFF_FFFF;
         eh  = a;
         edz = 1'b1;
      end else begin
         q  = xa / xb;
         r  = xa % xb;
         el = q[31:0];
         eh = r[31:0];
      end
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge Clock) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_HI", 64'(HI), 64'(e.hi));
            chk("result_LO", 64'(LO), 64'(e.lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic do_clear();
      #1 Clear = 1'b1;
      #1;
      chk("clear_busy", 64'(busy), 64'(0));
      chk("clear_done", 64'(done), 64'(0));
      chk("clear_HI", 64'(HI), 64'(0));
      chk("clear_LO", 64'(LO), 64'(0));
      exp_q.delete();
      mdl_hi = '0;
      mdl_lo = '0;
      @(negedge Clock);
      Clear = 1'b0;
   endtask

   // poke >= 0: HIin/LOin/start asserted during that RUN cycle, which must all be ignored.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit with_hiin, input int poke);
      exp_t e;
      logic [31:0] prev_hi, prev_lo;
      int waited;
      bit busy_ok;
      @(negedge Clock);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      if (with_hiin) begin
         HIin   = 1'b1;
         bus_in = $urandom;
         mdl_hi = bus_in;
      end
      model(o, a, b, e.hi, e.lo, e.dz);
      e.cyc = cyc + W + 2;
      exp_q.push_back(e);
      prev_hi = mdl_hi;
      prev_lo = mdl_lo;
      @(posedge Clock);
      #1;
      start = 1'b0;
      HIin  = 1'b0;
      chk("dz_cleared_on_start", 64'(div_by_zero), 64'(0));
      if (with_hiin) chk("hiin_with_start", 64'(HI), 64'(prev_hi));
      busy_ok = 1'b1;
      waited  = 0;
      while (done !== 1'b1 && waited < W + 8) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (waited == poke) begin
            HIin   = 1'b1;
            LOin   = 1'b1;
            bus_in = 32'h0000_1234;
            start  = 1'b1;
         end
         @(posedge Clock);
         #1;
         if (waited == poke) begin
            chk("hiin_during_run", 64'(HI), 64'(prev_hi));
            chk("loin_during_run", 64'(LO), 64'(prev_lo));
            HIin  = 1'b0;
            LOin  = 1'b0;
            start = 1'b0;
         end
         waited++;
      end
      if (done !== 1'b1) begin
         chk("done_timeout", 64'(done), 64'(1));
         do_clear();
      end else begin
         chk("busy_held_in_run_fix", 64'(busy_ok), 64'(1));
         chk("busy_low_in_done", 64'(busy), 64'(0));
         chk("busy_cycles", 64'(waited), 64'(W + 1));
         mdl_hi = e.hi;
         mdl_lo = e.lo;
         start  = 1'b1;
         op     = 2'($urandom_range(0, 3));
         @(posedge Clock);
         #1;
         start = 1'b0;
         chk("start_in_done_ignored", 64'(busy), 64'(0));
         chk("hold_HI_after_done", 64'(HI), 64'(mdl_hi));
      end
   endtask

   initial begin
      int poke;
      n_cmp  = 0;
      n_bad  = 0;
      mdl_hi = '0;
      mdl_lo = '0;
      Clear  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      A      = '0;
      B      = '0;
      bus_in = '0;
      HIin   = 1'b0;
      LOin   = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("reset_HI", 64'(HI), 64'(0));
      chk("reset_LO", 64'(LO), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_dz", 64'(div_by_zero), 64'(0));
      @(negedge Clock);
      Clear = 1'b0;

      // Direct bus loads in IDLE.
      @(negedge Clock);
      HIin   = 1'b1;
      bus_in = 32'h0000_1234;
      @(posedge Clock);
      #1;
      HIin = 1'b0;
      chk("hiin_idle_HI", 64'(HI), 64'(32'h1234));
      chk("hiin_idle_LO", 64'(LO), 64'(0));
      mdl_hi = 32'h1234;
      @(negedge Clock);
      LOin   = 1'b1;
      bus_in = 32'hCAFE_0001;
      @(posedge Clock);
      #1;
      LOin = 1'b0;
      chk("loin_idle_LO", 64'(LO), 64'(32'hCAFE_0001));
      mdl_lo = 32'hCAFE_0001;

      // Directed cases.
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
      run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, -1);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
      run_op(2'b01, 32'd100, 32'd0, 1'b0, -1);
      run_op(2'b01, 32'd100, 32'd7, 1'b0, 5);
      run_op(2'b00, 32'd3, 32'd4, 1'b1, -1);

      // Clear mid-RUN aborts; a fresh multiply follows.
      @(negedge Clock);
      start = 1'b1;
      op    = 2'b00;
      A     = 32'd123456;
      B     = 32'd789;
      @(posedge Clock);
      #1;
      start = 1'b0;
      repeat (9) @(posedge Clock);
      do_clear();
      run_op(2'b00, 32'd6, 32'd7, 1'b0, -1);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
         run_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0), poke);
      end

      repeat (3) @(posedge Clock);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

endmodule
